// File: rtl/mul8_seq_shift_add_pkg.sv
// Purpose: shared constants and FSM state type for the sequential shift-add multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mul8_seq_shift_add_pkg;

    localparam int DEF_WIDTH = 8;   // operand width; product is 2*WIDTH
    localparam int DEF_CNT_W = 4;   // iteration counter width, 2**CNT_W > WIDTH

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul8_seq_shift_add_mul_row.sv
// Purpose: one WIDTH x 1 partial-product row, {cout,sum} = acc_hi + (a_reg & {WIDTH{mq0}}).
// Latency: combinational, ripple carry from a half-adder LSB through full-adder cells.
// Backpressure: none (pure logic).
// Ports: a_reg (multiplicand), mq0 (current multiplier bit), acc_hi (running upper
//        accumulator) in; sum (WIDTH bits) and cout (row carry-out) out.
import mul8_seq_shift_add_pkg::*;

module mul_row #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a_reg,
    input  logic             mq0,
    input  logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] pp;       // partial product bits
    logic [WIDTH:1]   carry;    // carry into cell i lives at carry[i]

    assign pp = a_reg & {WIDTH{mq0}};

    // LSB cell has no carry-in, so a half adder suffices.
    assign sum[0]   = acc_hi[0] ^ pp[0];
    assign carry[1] = acc_hi[0] & pp[0];

    for (genvar i = 1; i < WIDTH; i++) begin : g_mfa
        assign sum[i]     = acc_hi[i] ^ pp[i] ^ carry[i];
        assign carry[i+1] = (acc_hi[i] & pp[i]) | (carry[i] & (acc_hi[i] ^ pp[i]));
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/mul8_seq_shift_add.sv
// Purpose: sequential unsigned WIDTH x WIDTH shift-add multiplier, one row per RUN cycle.
// Latency: accept at cycle 0, out_valid from cycle WIDTH+1 (cycle 1 for zero operands when
//          MUL_ZERO_SKIP_EN is defined); issue interval WIDTH+2.
// Backpressure: product held in DONE until out_ready; in_ready only in IDLE, so upstream holds.
// Ports: clk, rst (async active-high); in_valid/in_ready with a, b; out_valid/out_ready with
//        product (2*WIDTH, registered); busy high while iterating.
// Optional feature macro: MUL_ZERO_SKIP_EN (zero operand bypasses RUN).
import mul8_seq_shift_add_pkg::*;

module mul8_seq_shift_add #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] mq;       // multiplier bits shift out low, product low bits shift in high
    logic [WIDTH-1:0] acc_hi;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] row_sum;
    logic             row_cout;
    logic             accept;
    logic             last_iter;
    logic             zero_skip;

    mul_row #(.WIDTH(WIDTH)) u_row (
        .a_reg  (a_reg),
        .mq0    (mq[0]),
        .acc_hi (acc_hi),
        .sum    (row_sum),
        .cout   (row_cout)
    );

`ifdef MUL_ZERO_SKIP_EN
    assign zero_skip = (a == '0) || (b == '0);
`else
    assign zero_skip = 1'b0;
`endif

    assign accept    = (state == S_IDLE) && in_valid;
    assign last_iter = (cnt == CNT_W'(WIDTH-1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = zero_skip ? S_DONE : S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_iter) state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                // Handoff returns to IDLE; the next accept waits one cycle.
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg   <= '0;
            mq      <= '0;
            acc_hi  <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (accept) begin
            a_reg  <= a;
            mq     <= b;
            acc_hi <= '0;
            cnt    <= '0;
            if (zero_skip) product <= '0;
        end else if (state == S_RUN) begin
            acc_hi <= {row_cout, row_sum[WIDTH-1:1]};
            mq     <= {row_sum[0], mq[WIDTH-1:1]};
            cnt    <= cnt + CNT_W'(1);
            // Same value as {next acc_hi, next mq}, taken straight from the row outputs.
            if (last_iter) product <= {row_cout, row_sum, mq[WIDTH-1:1]};
        end
    end

endmodule

// File: tb/tb_mul8_seq_shift_add.sv
module tb_mul8_seq_shift_add;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] product;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    mul8_seq_shift_add dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input logic [7:0] ia, input logic [7:0] ib);
`ifdef MUL_ZERO_SKIP_EN
        if (ia == 8'd0 || ib == 8'd0) return 1;
`endif
        return 9;
    endfunction

    // Called at a negedge in IDLE; returns at the negedge of cycle 1.
    task automatic start_op(input logic [7:0] ia, input logic [7:0] ib);
        a = ia;
        b = ib;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Waits (bounded) for out_valid, checking busy meanwhile, then latency and product.
    task automatic wait_done(input string tag, input logic [7:0] ia, input logic [7:0] ib);
        int k;
        bit found;
        found = 0;
        for (k = 1; k <= 30; k++) begin
            if (out_valid) begin
                found = 1;
                break;
            end
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_inrdy_run"}, in_ready, 0);
            @(negedge clk);
        end
        chk({tag, "_lat"}, k, exp_lat(ia, ib));
        if (found) chk({tag, "_prod"}, product, 32'(ia) * 32'(ib));
    endtask

    // Handoff with out_ready=1 at the DONE cycle; next cycle must be IDLE.
    task automatic handoff(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_inrdy_after"}, in_ready, 1);
        chk({tag, "_ovld_after"}, out_valid, 0);
    endtask

    logic [7:0] pa[10];
    logic [7:0] pb[10];
    logic [15:0] expq[$];

    initial begin
        // Reset values
        #2;
        chk("rst_inrdy", in_ready, 1);
        chk("rst_ovld", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_prod", product, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Full-scale operands and a few distinct patterns
        start_op(8'd255, 8'd255);
        wait_done("ff_ff", 8'd255, 8'd255);
        chk("ff_ff_const", product, 16'hFE01);
        handoff("ff_ff");

        start_op(8'h0F, 8'hF0);
        wait_done("0f_f0", 8'h0F, 8'hF0);
        chk("0f_f0_const", product, 16'h0E10);
        handoff("0f_f0");

        start_op(8'h80, 8'h02);
        wait_done("80_02", 8'h80, 8'h02);
        chk("80_02_const", product, 16'h0100);
        handoff("80_02");

        // Zero operands (latency depends on build, result does not)
        start_op(8'd0, 8'd77);
        wait_done("z_a", 8'd0, 8'd77);
        chk("z_a_const", product, 16'h0000);
        handoff("z_a");

        start_op(8'd91, 8'd0);
        wait_done("z_b", 8'd91, 8'd0);
        chk("z_b_const", product, 16'h0000);
        handoff("z_b");

        // Backpressure: product and out_valid held while out_ready is low
        out_ready = 1'b0;
        start_op(8'd3, 8'd5);
        wait_done("bp", 8'd3, 8'd5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_ovld_hold", out_valid, 1);
            chk("bp_prod_hold", product, 16'd15);
            chk("bp_inrdy_low", in_ready, 0);
        end
        handoff("bp");

        // Reset in the middle of an operation
        start_op(8'd200, 8'd100);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_ovld", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_inrdy", in_ready, 1);
        chk("mid_rst_prod", product, 0);
        @(negedge clk);
        chk("mid_rst_ovld2", out_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        start_op(8'd7, 8'd6);
        wait_done("post_rst", 8'd7, 8'd6);
        chk("post_rst_const", product, 16'd42);
        handoff("post_rst");

        // Back-to-back with in_valid held high
        for (int i = 0; i < 10; i++) begin
            pa[i] = 8'($urandom_range(1, 255));
            pb[i] = 8'($urandom_range(1, 255));
        end
        begin
            int n_acc;
            int n_res;
            int cyc;
            int last_acc;
            n_acc = 0;
            n_res = 0;
            last_acc = -1;
            out_ready = 1'b1;
            a = pa[0];
            b = pb[0];
            in_valid = 1'b1;
            for (cyc = 0; cyc < 200 && n_res < 10; cyc++) begin
                if (out_valid) begin
                    if (expq.size() > 0) chk("b2b_prod", product, expq.pop_front());
                    n_res++;
                end
                if (in_ready && in_valid) begin
                    if (last_acc >= 0) chk("b2b_spacing", cyc - last_acc, 10);
                    last_acc = cyc;
                    expq.push_back(16'(pa[n_acc]) * 16'(pb[n_acc]));
                    n_acc++;
                    @(posedge clk);
                    #1;
                    if (n_acc < 10) begin
                        a = pa[n_acc];
                        b = pb[n_acc];
                    end else begin
                        in_valid = 1'b0;
                    end
                end
                @(negedge clk);
            end
            in_valid = 1'b0;
            chk("b2b_accepts", n_acc, 10);
            chk("b2b_results", n_res, 10);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
